// File: rtl/pipe_issue_scheduler_pkg.sv
// pipe_issue_scheduler_pkg: shared opcodes, idle flags and FSM state type
package pipe_issue_scheduler_pkg;
  localparam logic [3:0] sin_cos     = 4'd0;
  localparam logic [3:0] sinh_cosh   = 4'd1;
  localparam logic [3:0] arctan      = 4'd2;
  localparam logic [3:0] arctanh     = 4'd3;
  localparam logic [3:0] exponential = 4'd4;
  localparam logic [3:0] log         = 4'd5;
  localparam logic [3:0] sqrt        = 4'd6;
  localparam logic [3:0] division    = 4'd7;
  localparam logic [3:0] multiply    = 4'd8;
  localparam logic [3:0] addition    = 4'd9;
  localparam logic [3:0] subtraction = 4'd10;
  localparam logic [3:0] PreProcess  = 4'd11;
  localparam logic [3:0] OPCODE_MAX  = 4'd11;
  localparam logic no_idle  = 1'b0;
  localparam logic put_idle = 1'b1;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_FULL} state_e;
endpackage

// File: rtl/pipe_issue_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter (valid0_i/valid1_i/en_i in, gnt0_o/gnt1_o out)
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic en_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic ptr_q;
  assign gnt0_o = en_i & valid0_i & (~valid1_i | ~ptr_q);
  assign gnt1_o = en_i & valid1_i & (~valid0_i | ptr_q);
  always_ff @(posedge clock)
    ptr_q <= reset ? 1'b0 : (gnt0_o | gnt1_o) ? gnt0_o : ptr_q;
endmodule

// File: rtl/pipe_issue_scheduler.sv
// pipe_issue_scheduler: arbitrates requesters A/B into a credit-limited pipeline (issue_* out, inflight/err_* status)
module pipe_issue_scheduler
  import pipe_issue_scheduler_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_opcode,
  input  logic [31:0] a_z,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_opcode,
  input  logic [31:0] b_z,
  input  logic        retire_valid,
  output logic        issue_idle,
  output logic [3:0]  issue_opcode,
  output logic [31:0] issue_z,
  output logic [7:0]  issue_tag,
  output logic [3:0]  inflight,
  output logic        err_opcode,
  output logic        err_retire
);
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  state_e        state_q;
  logic [FW-1:0] flush_q;
  logic [6:0]    seq_a_q, seq_b_q;
  logic [3:0]    inflight_q, inflight_d;
  logic          en, xfer, legal, issue, ret, under;
  logic [3:0]    op;
  logic [31:0]   z;
  assign en = !reset && (state_q == S_RUN || (state_q == S_FULL && retire_valid));
  rr_arb2 u_arb (
    .clock(clock), .reset(reset), .valid0_i(a_valid), .valid1_i(b_valid),
    .en_i(en), .gnt0_o(a_ready), .gnt1_o(b_ready)
  );
  assign op       = b_ready ? b_opcode : a_opcode;
  assign z        = b_ready ? b_z : a_z;
  assign xfer     = a_ready | b_ready;
  assign legal    = op <= OPCODE_MAX;
  assign issue    = xfer && legal;
  assign ret      = retire_valid && state_q != S_INIT;
  assign under    = ret && !issue && inflight_q == 4'd0;
  assign inflight = inflight_q;
  always_comb
    inflight_d = (issue && !ret) ? inflight_q + 4'd1 :
                 (ret && !issue && !under) ? inflight_q - 4'd1 : inflight_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_INIT;
      flush_q      <= '0;
      issue_idle   <= put_idle;
      issue_opcode <= '0;
      issue_z      <= '0;
      issue_tag    <= '0;
      inflight_q   <= '0;
      seq_a_q      <= '0;
      seq_b_q      <= '0;
      err_opcode   <= 1'b0;
      err_retire   <= 1'b0;
    end else begin
      state_q    <= state_q == S_INIT ? (int'(flush_q) + 1 >= FLUSH_CYCLES ? S_RUN : S_INIT) :
                    inflight_d == 4'(MAX_INFLIGHT) ? S_FULL : S_RUN;
      flush_q    <= flush_q + FW'(state_q == S_INIT);
      issue_idle <= issue ? no_idle : put_idle;
      if (issue) begin
        issue_opcode <= op;
        issue_z      <= z;
        issue_tag    <= b_ready ? {1'b1, seq_b_q} : {1'b0, seq_a_q};
      end
      seq_a_q    <= seq_a_q + 7'(issue && a_ready);
      seq_b_q    <= seq_b_q + 7'(issue && b_ready);
      inflight_q <= inflight_d;
      err_opcode <= err_opcode | (xfer && !legal);
      err_retire <= err_retire | under;
    end
  end
endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// tb_pipe_issue_scheduler: directed table and sequence checks for pipe_issue_scheduler
module tb_pipe_issue_scheduler;
  logic        clock = 1'b0, reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, retire_valid = 1'b0;
  logic [3:0]  a_opcode = '0, b_opcode = '0;
  logic [31:0] a_z = '0, b_z = '0;
  logic        a_ready, b_ready, issue_idle, err_opcode, err_retire;
  logic [3:0]  issue_opcode, inflight;
  logic [31:0] issue_z;
  logic [7:0]  issue_tag;
  int tests = 0, fails = 0;
  pipe_issue_scheduler dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_z(a_z),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_z(b_z),
    .retire_valid(retire_valid), .issue_idle(issue_idle), .issue_opcode(issue_opcode),
    .issue_z(issue_z), .issue_tag(issue_tag), .inflight(inflight),
    .err_opcode(err_opcode), .err_retire(err_retire)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic av; logic [3:0] aop; logic bv; logic [3:0] bop; logic ret;
    logic ea; logic eb; logic eidle; logic [3:0] eop; logic [31:0] ez; logic [7:0] etag; logic [3:0] einf;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set_in(input logic av, input logic [3:0] aop, input logic [31:0] az,
                        input logic bv, input logic [3:0] bop, input logic [31:0] bz, input logic ret);
    a_valid = av; a_opcode = aop; a_z = az;
    b_valid = bv; b_opcode = bop; b_z = bz;
    retire_valid = ret;
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b1, 4'd4, 32'h1234, 1'b1, 4'd2, 32'h5678, 1'b1);
    chk("rst a_ready", 32'(a_ready), 32'd0);
    chk("rst b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("rst idle", 32'(issue_idle), 32'd1);
    chk("rst opcode", 32'(issue_opcode), 32'd0);
    chk("rst z", issue_z, 32'd0);
    chk("rst tag", 32'(issue_tag), 32'd0);
    chk("rst inflight", 32'(inflight), 32'd0);
    chk("rst err_opcode", 32'(err_opcode), 32'd0);
    chk("rst err_retire", 32'(err_retire), 32'd0);
    reset = 1'b0;
    #1;
  endtask
  task automatic flush_chk();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("flush%0d a_ready", k), 32'(a_ready), 32'd0);
      chk($sformatf("flush%0d b_ready", k), 32'(b_ready), 32'd0);
      chk($sformatf("flush%0d idle", k), 32'(issue_idle), 32'd1);
      tick();
    end
    chk("flush err_retire", 32'(err_retire), 32'd0);
  endtask
  initial begin
    logic [7:0] tags36 [4];
    tags36[0] = 8'h00; tags36[1] = 8'h80; tags36[2] = 8'h01; tags36[3] = 8'h81;
    //           av   aop   bv   bop   ret  ea   eb   idle op    z             tag    inf
    vt[0] = '{1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2,  32'hB0000000, 8'h80, 4'd2};
    vt[1] = '{1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  32'hA0000001, 8'h01, 4'd3};
    vt[2] = '{1'b1, 4'd5, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  32'hB0000002, 8'h81, 4'd3};
    vt[3] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  32'hB0000002, 8'h81, 4'd3};
    vt[4] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  32'hB0000002, 8'h81, 4'd2};
    vt[5] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  32'hB0000005, 8'h82, 4'd3};
    vt[6] = '{1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 32'hA0000006, 8'h02, 4'd4};
    vt[7] = '{1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  32'hA0000007, 8'h03, 4'd5};
    vt[8] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  32'hA0000007, 8'h03, 4'd4};
    do_reset();
    flush_chk();
    set_in(1'b1, 4'd4, 32'hA5A50004, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("first a_ready", 32'(a_ready), 32'd1);
    chk("first b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("first idle", 32'(issue_idle), 32'd0);
    chk("first opcode", 32'(issue_opcode), 32'd4);
    chk("first z", issue_z, 32'hA5A50004);
    chk("first tag", 32'(issue_tag), 32'h00);
    chk("first inflight", 32'(inflight), 32'd1);
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].av, vt[i].aop, 32'hA0000000 + 32'(i), vt[i].bv, vt[i].bop, 32'hB0000000 + 32'(i), vt[i].ret);
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vt[i].ea));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vt[i].eb));
      tick();
      chk($sformatf("v%0d idle", i), 32'(issue_idle), 32'(vt[i].eidle));
      chk($sformatf("v%0d opcode", i), 32'(issue_opcode), 32'(vt[i].eop));
      chk($sformatf("v%0d z", i), issue_z, vt[i].ez);
      chk($sformatf("v%0d tag", i), 32'(issue_tag), 32'(vt[i].etag));
      chk($sformatf("v%0d inflight", i), 32'(inflight), 32'(vt[i].einf));
    end
    do_reset();
    flush_chk();
    set_in(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d a_ready", k), 32'(a_ready), 32'(k % 2 == 0));
      chk($sformatf("rr%0d b_ready", k), 32'(b_ready), 32'(k % 2 == 1));
      tick();
      chk($sformatf("rr%0d tag", k), 32'(issue_tag), 32'(tags36[k]));
    end
    set_in(1'b1, 4'd6, 32'hA6, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d a_ready", k), 32'(a_ready), 32'd1);
      tick();
      chk($sformatf("fill%0d inflight", k), 32'(inflight), 32'(5 + k));
    end
    set_in(1'b1, 4'd6, 32'hA6, 1'b1, 4'd2, 32'hB1, 1'b0);
    chk("full a_ready", 32'(a_ready), 32'd0);
    chk("full b_ready", 32'(b_ready), 32'd0);
    tick();
    chk("full idle", 32'(issue_idle), 32'd1);
    chk("full inflight", 32'(inflight), 32'd8);
    set_in(1'b1, 4'd6, 32'hC0DE0006, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("bypass a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("bypass idle", 32'(issue_idle), 32'd0);
    chk("bypass tag", 32'(issue_tag), 32'h06);
    chk("bypass inflight", 32'(inflight), 32'd8);
    set_in(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    repeat (8) tick();
    chk("drain inflight", 32'(inflight), 32'd0);
    chk("drain err_retire", 32'(err_retire), 32'd0);
    set_in(1'b1, 4'd13, 32'hDEAD0000, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("illegal a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("illegal idle", 32'(issue_idle), 32'd1);
    chk("illegal inflight", 32'(inflight), 32'd0);
    chk("illegal err_opcode", 32'(err_opcode), 32'd1);
    chk("illegal tag hold", 32'(issue_tag), 32'h06);
    chk("illegal z hold", issue_z, 32'hC0DE0006);
    set_in(1'b1, 4'd4, 32'hA4, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("post-illegal tag", 32'(issue_tag), 32'h07);
    chk("err_opcode sticky", 32'(err_opcode), 32'd1);
    chk("post-illegal inflight", 32'(inflight), 32'd1);
    set_in(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    tick();
    chk("retire inflight", 32'(inflight), 32'd0);
    chk("retire no err", 32'(err_retire), 32'd0);
    tick();
    chk("underflow inflight", 32'(inflight), 32'd0);
    chk("underflow err_retire", 32'(err_retire), 32'd1);
    set_in(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("err_retire sticky", 32'(err_retire), 32'd1);
    do_reset();
    flush_chk();
    set_in(1'b1, 4'd4, 32'hA4, 1'b0, 4'd0, 32'd0, 1'b1);
    repeat (128) tick();
    chk("wrap tag 127", 32'(issue_tag), 32'h7F);
    tick();
    chk("wrap tag 0", 32'(issue_tag), 32'h00);
    chk("wrap inflight", 32'(inflight), 32'd0);
    chk("wrap err_retire", 32'(err_retire), 32'd0);
    set_in(1'b1, 4'd4, 32'hA4, 1'b0, 4'd0, 32'd0, 1'b0);
    repeat (5) tick();
    chk("pre-reset inflight", 32'(inflight), 32'd5);
    set_in(1'b1, 4'd14, 32'hA4, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("pre-reset err_opcode", 32'(err_opcode), 32'd1);
    chk("pre-reset inflight hold", 32'(inflight), 32'd5);
    do_reset();
    flush_chk();
    set_in(1'b1, 4'd4, 32'hA4, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("post-reset a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("post-reset tag", 32'(issue_tag), 32'h00);
    chk("post-reset inflight", 32'(inflight), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_issue_scheduler.md
PIPE_ISSUE_SCHEDULER -- requirements
Module: pipe_issue_scheduler

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8, maximum operations in flight in the downstream special/align/adder pipeline (range 1..15).
REQ-002 Parameter FLUSH_CYCLES, default 4, number of idle bubbles issued after reset.
REQ-003 clock  in  1  sole clock; all logic on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 a_valid  in  1  requester A has an operation.
REQ-006 a_ready  out  1  requester A operation accepted this cycle.
REQ-007 a_opcode  in  4  requester A opcode (0..11 legal).
REQ-008 a_z  in  32  requester A operand.
REQ-009 b_valid / b_ready / b_opcode / b_z  in/out/in/in  1/1/4/32  requester B, same meaning as A.
REQ-010 retire_valid  in  1  pipeline tail completed one operation.
REQ-011 issue_idle  out  1  1 = put_idle bubble, 0 = live operation.
REQ-012 issue_opcode  out  4  issued opcode.
REQ-013 issue_z  out  32  issued operand.
REQ-014 issue_tag  out  8  {source bit (0=A, 1=B), 7-bit per-source sequence}.
REQ-015 inflight  out  4  current in-flight count.
REQ-016 err_opcode / err_retire  out  1/1  sticky error flags.

Function
REQ-017 FSM states: S_INIT, S_RUN, S_FULL; encoding shall be taken from the shared package.
REQ-018 S_INIT shall issue issue_idle=1 for FLUSH_CYCLES cycles, hold both readies at 0, and then go to S_RUN.
REQ-019 S_RUN shall go to S_FULL when the next-cycle inflight equals MAX_INFLIGHT; S_FULL shall return to S_RUN when it drops below MAX_INFLIGHT.
REQ-020 A grant shall be possible only in S_RUN, or in S_FULL with retire_valid=1 in the same cycle (credit bypass).
REQ-021 Readies shall be combinational: at most one of a_ready/b_ready is high; a ready shall never be high while its valid is low.
REQ-022 Arbitration shall be round-robin:
- a 1-bit pointer gives priority when both requesters are valid;
- after any grant the pointer shall point to the non-granted source;
- with a single valid requester, that requester shall be granted regardless of the pointer.
REQ-023 A transfer (valid && ready) shall register issue_idle=0, the opcode, the operand and the tag on the next edge, giving 1-cycle latency.
REQ-024 In cycles with no transfer, issue_idle shall be 1 and issue_opcode/issue_z/issue_tag shall hold their last values.
REQ-025 The per-source 7-bit sequence shall increment on each legal transfer from that source and wrap from 127 to 0.
REQ-026 An illegal opcode (12..15) shall be accepted (ready=1) but not issued, leaving issue_idle=1 and no sequence or inflight change, and shall set err_opcode.
REQ-027 inflight shall follow the legal issues and retires in the same cycle:
- +1 on a legal issue only;
- -1 on retire only;
- unchanged when both occur;
- it shall never exceed MAX_INFLIGHT.
REQ-028 retire_valid with inflight=0 and no simultaneous issue shall be ignored (count stays 0) and shall set err_retire.
REQ-029 retire_valid during S_INIT shall be ignored without setting err_retire.

Reset
REQ-030 Reset shall set:
- state=S_INIT, flush counter=0;
- issue_idle=1, issue_opcode=0, issue_z=0, issue_tag=0;
- inflight=0, both sequences=0, pointer=A;
- err_opcode=0, err_retire=0.
REQ-031 With reset=1, a_ready and b_ready shall be 0.
REQ-032 Reset asserted mid-operation shall abandon all in-flight accounting without error, and the block shall re-enter S_INIT.

Structure
REQ-033 A shared package shall hold:
- the opcode constants (sin_cos=0 .. PreProcess=11);
- the OPCODE_MAX=11 constant;
- the idle constants no_idle=0/put_idle=1;
- the FSM state typedef.
REQ-034 The round-robin arbiter shall be one sub-module, rr_arb2 (inputs: two valids, enable; outputs: two grants; internal pointer).

Verification
REQ-035 Reset release: exactly 4 cycles of issue_idle=1 with readies 0, then a_valid=1 with opcode 4 -> a_ready=1, and the next cycle shows issue_idle=0, issue_opcode=4, issue_tag=0x00.
REQ-036 Both requesters valid for 4 cycles with the pointer at A -> grants A,B,A,B and tags 0x00,0x80,0x01,0x81.
REQ-037 Credits: 8 issues with no retire -> inflight=8, S_FULL, readies 0; then retire_valid=1 with a_valid=1 in the same cycle -> one grant, inflight stays 8.
REQ-038 Illegal opcode: a_opcode=13 -> a_ready=1, issue_idle stays 1, inflight unchanged, err_opcode=1 and sticky.
REQ-039 Underflow: retire_valid=1 in S_RUN with inflight=0 -> inflight stays 0, err_retire=1.
REQ-040 Wrap and mid-reset: 128 A issues -> tag returns to 0x00; reset asserted with inflight=5 -> inflight=0, errors 0, 4 flush bubbles.
